dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single byte-addressed data memory (32-bit word, 4 byte-lane write enables, combinational read, write on rising `clk`) between the CPU load/store port (requester 0) and a debug/loader port (requester 1). It sits between the requesters and `dmem`. It accepts at most one access per cycle with valid/ready handshakes, drives registered memory-side signals, and returns a registered one-cycle response. Arbitration is round-robin, with an optional bounded lock for short bursts.

## Interface

Parameters:
- `MAX_BURST`, 4: maximum consecutive grants a locked requester keeps while the other requester is waiting. Legal range 1..15.

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid`, in, 1 each: access request.
- `req0_ready`, `req1_ready`, out, 1 each: request accepted in this cycle.
- `req0_addr`, `req1_addr`, in, 32 each: byte address.
- `req0_wdata`, `req1_wdata`, in, 32 each: lane-replicated write data.
- `req0_we`, `req1_we`, in, 4 each: byte-lane write enables. Zero means read.
- `req0_lock`, `req1_lock`, in, 1 each: request to keep the grant on the next tie.
- `rsp0_valid`, `rsp1_valid`, out, 1 each: one-cycle response pulse.
- `rsp0_rdata`, `rsp1_rdata`, out, 32 each: read word.
- `mem_en`, out, 1: memory access active in this cycle.
- `mem_addr`, out, 32: to dmem `daddr`.
- `mem_wdata`, out, 32: to dmem `dwdata`.
- `mem_we`, out, 4: to dmem `we`.
- `mem_rdata`, in, 32: from dmem `drdata`.

## Operation

- **Handshake:**
  - A transfer occurs on a rising edge where `reqX_valid & reqX_ready` is high.
  - A requester holds `valid`, `addr`, `wdata`, `we` and `lock` stable until accepted.
  - `valid` never depends on `ready`. `ready` depends combinationally on both `valid` inputs and on registered state.
  - At most one `ready` is high per cycle, and `ready` is never high without its `valid`.
- **Grant selection:**
  - Neither valid: no grant.
  - One valid: that requester is granted.
  - Both valid: the last-granted requester L is granted if `reqL_lock`=1 and `burst_cnt` < `MAX_BURST`. Otherwise the other requester is granted.
- **State registers:**
  - `last_grant` (1 bit), updated on every grant.
  - `burst_cnt` (4 bits), updated as follows:
    - Grant to the same requester as `last_grant`: increment, saturating at `MAX_BURST`.
    - Grant to the other requester: set to 1.
    - Cycle with no grant: set to 0.
- **Pipeline:** `idle -> ACCESS -> RESP`, overlapping, one access per cycle.
  - The accepted request is registered into `mem_addr`, `mem_wdata` and `mem_we`, with `mem_en`=1 and a 1-bit `owner` register.
  - In ACCESS, dmem writes the enabled lanes at the ending edge. For reads, `mem_rdata` is captured into `rsp<owner>_rdata` at that edge.
  - `rsp<owner>_valid`=1 in the following cycle. For writes, `rspX_rdata`=0 (write acknowledge).
  - Cycles without an accept: `mem_en`=0 and `mem_we`=0. `mem_addr` and `mem_wdata` hold their last value.
- **Pass-through:** addresses and enables are passed unmodified, with no alignment checks (dmem aligns to the word).
- **Response data:** `rspX_rdata` holds its value until the next response to X.

## Timing

- **Reset (asynchronous, `reset`=0):**
  - Outputs: `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rsp*_valid`=0, `rsp*_rdata`=0.
  - State: `last_grant`=1 (requester 0 wins the first tie), `burst_cnt`=0, `owner`=0.
  - `req*_ready` is forced to 0 while `reset`=0.
- **Latency:** accept edge ending cycle N; memory access during cycle N+1; response during cycle N+2.
- **Throughput:** one access per cycle, sustained.
- **Read-after-write:** back-to-back write then read to the same word returns the new data, because the write commits at the end of N+1 and the read occurs in N+2.
- **Reset mid-operation:** the in-flight ACCESS is dropped. `mem_we` falls to 0 asynchronously, so no partial write occurs, and the pending response is discarded. After release, a held request is re-arbitrated as new.
- **Simultaneous events:** a response for one requester and an accept for the other may occur in the same cycle. Both `rsp*_valid` are never high together.

## Test plan

- **Single read:** `req0` read, `addr`=0x10, with memory word 0x13121110 (dmem's default init bytes) -> `ready0` in cycle 0; `mem_en`=1, `mem_addr`=0x10, `mem_we`=0 in cycle 1; `rsp0_valid`=1, `rdata`=0x13121110 in cycle 2.
- **Write then read:** `req1` SB to 0x21 with `we`=0010, `wdata`=0xABABABAB, followed next cycle by a read of 0x20 -> `rsp1` write ack with `rdata`=0; the read returns byte 1 = 0xAB and the other bytes unchanged.
- **Tie without lock:** both valid continuously for 6 cycles with `lock`=0 -> grants 0,1,0,1,0,1 (first tie after reset goes to 0).
- **Tie with lock:** both valid, `req0_lock`=1, `MAX_BURST`=4 -> grants 0,0,0,0,1,0,0,0,0,1.
- **Reset during write:** `reset`=0 asserted during an ACCESS cycle of a write to 0x40 -> `mem_we`=0 immediately; memory at 0x40 unchanged; no `rsp` pulse; all outputs at reset values.
- **Idle clears burst:** single requester 0 streaming reads with `lock`=1 for 3 grants, one idle cycle, then both valid -> `burst_cnt` resets to 0 and requester 0 (`last_grant`) is granted, with `burst_cnt` incrementing from 1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU port (0) and the debug/loader port (1).
// Registered memory-side signals and a registered one-cycle response per requester.
module dmem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req0_wdata,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req0_we,
    input  logic [3:0]  req1_we,
    input  logic        req0_lock,
    input  logic        req1_lock,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp0_rdata,
    output logic [31:0] rsp1_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic        last_grant;
    logic [3:0]  burst_cnt;
    logic        owner;

    logic        both_valid;
    logic        lock_last;
    logic        keep_last;
    logic        grant_any;
    logic        grant_sel;
    logic [31:0] rsp_word;

    always_comb begin
        both_valid = req0_valid & req1_valid;
        lock_last  = last_grant ? req1_lock : req0_lock;
        keep_last  = lock_last && (burst_cnt < BURST_MAX);
        // ready is gated by reset so nothing is accepted while the block is held in reset
        grant_any  = reset & (req0_valid | req1_valid);
        if (both_valid) begin
            grant_sel = keep_last ? last_grant : ~last_grant;
        end else begin
            grant_sel = req1_valid;
        end
    end

    assign req0_ready = grant_any & ~grant_sel;
    assign req1_ready = grant_any & grant_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            burst_cnt  <= 4'd0;
        end else if (grant_any) begin
            last_grant <= grant_sel;
            if (grant_sel == last_grant) begin
                burst_cnt <= (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 4'd1;
            end else begin
                burst_cnt <= 4'd1;
            end
        end else begin
            burst_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_we    <= 4'd0;
            owner     <= 1'b0;
        end else begin
            mem_en <= grant_any;
            if (grant_any) begin
                mem_addr  <= grant_sel ? req1_addr  : req0_addr;
                mem_wdata <= grant_sel ? req1_wdata : req0_wdata;
                mem_we    <= grant_sel ? req1_we    : req0_we;
                owner     <= grant_sel;
            end else begin
                mem_we <= 4'd0;
            end
        end
    end

    // Writes acknowledge with zero data; reads return the word dmem presents this cycle.
    assign rsp_word = (mem_we == 4'd0) ? mem_rdata : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= 32'd0;
            rsp1_rdata <= 32'd0;
        end else begin
            rsp0_valid <= mem_en & ~owner;
            rsp1_valid <= mem_en & owner;
            if (mem_en && !owner) begin
                rsp0_rdata <= rsp_word;
            end
            if (mem_en && owner) begin
                rsp1_rdata <= rsp_word;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: arbitration vector table plus pipeline and reset sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_addr = 32'd0, req1_addr = 32'd0;
    logic [31:0] req0_wdata = 32'd0, req1_wdata = 32'd0;
    logic [3:0]  req0_we = 4'd0, req1_we = 4'd0;
    logic        req0_lock = 1'b0, req1_lock = 1'b0;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    logic [31:0] mem [0:63];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic rst;
        logic v0, v1, l0, l1;
        logic e0, e1;
    } vec_t;
    vec_t vecs[$];

    dmem_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_we(req0_we), .req1_we(req1_we),
        .req0_lock(req0_lock), .req1_lock(req1_lock),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_rdata(rsp0_rdata), .rsp1_rdata(rsp1_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // dmem stand-in: byte at address a initialised to a[7:0], combinational read
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic v0, input logic v1,
                       input logic l0, input logic l1, input logic e0, input logic e1);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.v1 = v1; v.l0 = l0; v.l1 = l1; v.e0 = e0; v.e1 = e1;
        vecs.push_back(v);
    endtask

    task automatic drop_all();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_lock = 1'b0;  req1_lock = 1'b0;
        req0_we = 4'd0;    req1_we = 4'd0;
    endtask

    task automatic do_reset();
        drop_all();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 64; k++)
            mem[k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};

        // tie without lock: alternate starting with 0
        add(1,1,1,0,0,1,0); add(0,1,1,0,0,0,1); add(0,1,1,0,0,1,0);
        add(0,1,1,0,0,0,1); add(0,1,1,0,0,1,0); add(0,1,1,0,0,0,1);
        // tie with req0 locked, burst of 4
        add(1,1,1,1,0,1,0); add(0,1,1,1,0,1,0); add(0,1,1,1,0,1,0); add(0,1,1,1,0,1,0);
        add(0,1,1,1,0,0,1);
        add(0,1,1,1,0,1,0); add(0,1,1,1,0,1,0); add(0,1,1,1,0,1,0); add(0,1,1,1,0,1,0);
        add(0,1,1,1,0,0,1);
        // 3 locked grants, idle clears count, then a full burst of 4 again
        add(1,1,0,1,0,1,0); add(0,1,0,1,0,1,0); add(0,1,0,1,0,1,0);
        add(0,0,0,1,0,0,0);
        add(0,1,1,1,0,1,0); add(0,1,1,1,0,1,0); add(0,1,1,1,0,1,0); add(0,1,1,1,0,1,0);
        add(0,1,1,1,0,0,1);
        // lone requester 1, then tie goes to 0
        add(1,0,1,0,0,0,1); add(0,1,1,0,0,1,0); add(0,1,1,0,0,0,1);
        // requester 1 locked keeps the tie
        add(1,0,1,0,1,0,1); add(0,1,1,0,1,0,1); add(0,1,1,0,1,0,1);

        // reset state, ready forced low during reset
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("rst_rdata0", rsp0_rdata, 32'd0);

        // arbitration table
        req0_addr = 32'h10; req1_addr = 32'h14;
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
            req0_lock  = vecs[i].l0; req1_lock  = vecs[i].l1;
            #1;
            chk($sformatf("v%0d_ready0", i), {31'd0, req0_ready}, {31'd0, vecs[i].e0});
            chk($sformatf("v%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vecs[i].e1});
            tick();
            chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].e0 | vecs[i].e1});
            chk($sformatf("v%0d_rsp_excl", i), {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
        end

        // single read from 0x10
        do_reset();
        req0_valid = 1'b1; req0_addr = 32'h10; req0_we = 4'd0;
        #1 chk("rd_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("rd_mem_en", {31'd0, mem_en}, 32'd1);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_mem_we", {28'd0, mem_we}, 32'd0);
        chk("rd_rsp0_early", {31'd0, rsp0_valid}, 32'd0);
        tick();
        chk("rd_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("rd_rsp0_rdata", rsp0_rdata, 32'h13121110);
        chk("rd_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rd_idle_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        chk("rd_rsp0_drop", {31'd0, rsp0_valid}, 32'd0);
        chk("rd_rdata_hold", rsp0_rdata, 32'h13121110);

        // byte write to 0x21 then read of 0x20
        req1_valid = 1'b1; req1_addr = 32'h21; req1_we = 4'b0010; req1_wdata = 32'hABABABAB;
        #1 chk("wr_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        chk("wr_mem_addr", mem_addr, 32'h21);
        chk("wr_mem_we", {28'd0, mem_we}, 32'h2);
        chk("wr_mem_wdata", mem_wdata, 32'hABABABAB);
        req1_addr = 32'h20; req1_we = 4'd0;
        #1 chk("rw_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("wr_ack_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("wr_ack_rdata", rsp1_rdata, 32'd0);
        chk("rw_mem_addr", mem_addr, 32'h20);
        chk("rw_mem_we", {28'd0, mem_we}, 32'd0);
        tick();
        chk("rw_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("rw_rsp1_rdata", rsp1_rdata, 32'h2322AB20);

        // reset asserted during the ACCESS cycle of a write to 0x40
        req0_valid = 1'b1; req0_addr = 32'h40; req0_we = 4'hF; req0_wdata = 32'hDEADBEEF;
        #1 chk("rw40_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        chk("rw40_mem_we", {28'd0, mem_we}, 32'hF);
        req0_valid = 1'b0; req0_we = 4'd0;
        req1_valid = 1'b1; req1_addr = 32'h14; req1_we = 4'd0;
        #2 reset = 1'b0;
        #1;
        chk("mid_mem_we", {28'd0, mem_we}, 32'd0);
        chk("mid_mem_en", {31'd0, mem_en}, 32'd0);
        chk("mid_mem_addr", mem_addr, 32'd0);
        chk("mid_mem_wdata", mem_wdata, 32'd0);
        chk("mid_ready1", {31'd0, req1_ready}, 32'd0);
        chk("mid_rdata1", rsp1_rdata, 32'd0);
        tick();
        chk("mid_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("mid_mem40", mem[16], 32'h43424140);
        reset = 1'b1;
        #1 chk("post_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("post_mem_addr", mem_addr, 32'h14);
        tick();
        chk("post_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("post_rsp1_rdata", rsp1_rdata, 32'h17161514);
        chk("post_mem40", mem[16], 32'h43424140);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
